memory_ctrl: RTL and testbench
==============================

Name: memory_ctrl

Overview:
Parametrised single-port RAM with a request/ready handshake and configurable read latency. It replaces the fixed 256-byte, 1-cycle memory. Every request is serviced; there is no last-address suppression. It sits between the CPU load/store unit and on-chip storage, with one outstanding request at a time.

Parameters:
DATA_W, 8, data word width in bits
DEPTH, 1024, number of words; must be a power of two and at least 2
READ_LAT, 2, cycles from read accept to ready pulse; must be 1..15
ADDR_W, 32, width of the caller's address bus

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
addr  in  ADDR_W  word address
data_in  in  DATA_W  write data
data_out  out  DATA_W  read data; valid when ready=1 for a read
memory_read_en  in  1  read request, level, sampled in IDLE
memory_write_en  in  1  write request, level, sampled in IDLE
ready  out  1  one-cycle completion pulse
busy  out  1  high in any state other than IDLE
err  out  1  one-cycle error pulse, coincident with ready

Behaviour:
- Reset (rst_n=0, async): state=IDLE; ready=0, busy=0, err=0, data_out=0; latency counter=0. An in-flight read is aborted and gives no ready. Memory contents are untouched.
- Storage has no reset. Simulation/FPGA init value is mem[i] = i truncated to DATA_W.
- Index = addr[$clog2(DEPTH)-1:0]; upper address bits are ignored (wrap), unless MEM_BOUNDS_CHECK_EN.
- FSM states: IDLE, RD_WAIT, RESP.
- IDLE, read_en=1: latch index, counter=READ_LAT-1.
  - If READ_LAT=1, go to RESP.
  - Otherwise go to RD_WAIT.
- IDLE, write_en=1 and read_en=0: mem[index] <= data_in at this edge; go to RESP.
- IDLE, both enables high: the read is serviced and the write is dropped; err pulses with that read's ready.
- RD_WAIT: decrement the counter; at 0, load data_out from the latched index and go to RESP.
- RESP: ready=1 for exactly one cycle; next state is IDLE.
  - For a read, data_out holds until the next read completes; it is not cleared on writes.
- Enables seen outside IDLE are ignored, not queued. A level-held enable re-issues the request on the IDLE cycle after RESP.
- Request spacing: read every READ_LAT+2 cycles minimum; write every 2.
- Read-after-write to the same index returns the new data, because the write commits before RESP.
- Latency: read accept edge to ready-high = READ_LAT cycles; write accept to ready = 1 cycle.
- busy=1 in RD_WAIT and RESP.

Optional Feature:
Macro MEM_BOUNDS_CHECK_EN.
- Defined: any addr >= DEPTH (full ADDR_W compare) is an error.
  - Write: dropped, ready+err pulse.
  - Read: data_out=0, ready+err pulse after the normal latency.
- Undefined: the address wraps modulo DEPTH; err only flags simultaneous enables.

Decomposition:
- Package mem_pkg: state enum (IDLE, RD_WAIT, RESP); localparam IDX_W=$clog2(DEPTH) helper; LAT_W=4 counter width constant.
- Sub-module mem_array: storage, sync write, registered read, init pattern.
- memory_ctrl holds the FSM, counter, error logic and output registers.

Test Plan:
- Reset, then read addr=5, READ_LAT=2: ready high 2 cycles after accept, data_out=0x05, err=0.
- Write 0xA5 to addr=17, then read 17: write ready after 1 cycle; read returns 0xA5.
- Both enables, addr=3, data_in=0xFF: ready+err pulse, data_out=0x03, mem[3] still 0x03.
- Hold read_en at addr=9 for 12 cycles (READ_LAT=2): exactly 3 ready pulses, every 4 cycles, each 0x09.
- Out of range, DEPTH=1024:
  - Read addr=1029 without macro returns 0x05, err=0.
  - With MEM_BOUNDS_CHECK_EN: data_out=0, err=1.
  - With MEM_BOUNDS_CHECK_EN, write 0x77 to addr=1029: mem[5] unchanged.
- rst_n low in RD_WAIT: no ready, all outputs 0. After release, read addr=7 returns 0x07 normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and sizing helpers for memory_ctrl and its storage array.
// Latency: none (package only).
// Backpressure: none.
package mem_pkg;

    localparam int LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RD_WAIT = 2'd1,
        RESP    = 2'd2
    } state_t;

    function automatic int idx_w(input int depth);
        return (depth < 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/mem_array.sv
// Single-port word storage: synchronous write, registered read with enable.
// Latency: read data appears one edge after rd_en_i; write commits on its edge.
// Backpressure: none; the caller never issues a read and a write together.
module mem_array
    import mem_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 1024,
    parameter int IDX_W  = idx_w(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en_i,
    input  logic [IDX_W-1:0]  wr_idx_i,
    input  logic [DATA_W-1:0] wr_dat_i,
    input  logic              rd_en_i,
    input  logic [IDX_W-1:0]  rd_idx_i,
    output logic [DATA_W-1:0] rd_dat_o
);

    // Words are stored XOR-ed with their own index, so the all-zero power-up
    // image reads back as the required mem[i] = i pattern.
    logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};
    logic [DATA_W-1:0] rd_dat_q;

    function automatic logic [DATA_W-1:0] pat(input logic [IDX_W-1:0] i);
        return DATA_W'(i);
    endfunction

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            mem[wr_idx_i] <= wr_dat_i ^ pat(wr_idx_i);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_dat_q <= '0;
        end else if (rd_en_i) begin
            rd_dat_q <= mem[rd_idx_i] ^ pat(rd_idx_i);
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/memory_ctrl.sv
// Request/ready RAM front end; optional MEM_BOUNDS_CHECK_EN flags addr >= DEPTH.
// Latency: write ready in the cycle after accept; read ready READ_LAT edges after accept.
// Backpressure: one request at a time; enables are only sampled while idle.
module memory_ctrl
    import mem_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int DEPTH    = 1024,
    parameter int READ_LAT = 2,
    parameter int ADDR_W   = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] data_in,
    output logic [DATA_W-1:0] data_out,
    input  logic              memory_read_en,
    input  logic              memory_write_en,
    output logic              ready,
    output logic              busy,
    output logic              err
);

    localparam int IDX_W = idx_w(DEPTH);

    state_t             state_q, state_d;
    logic [LAT_W-1:0]   cnt_q, cnt_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               err_q, err_d;
    logic               oob_q, oob_d;
    logic               zero_q, zero_d;
    logic [IDX_W-1:0]   addr_idx;
    logic               oob;
    logic               wr_en, rd_en;
    logic [IDX_W-1:0]   rd_idx;
    logic [DATA_W-1:0]  rd_dat;

    assign addr_idx = addr[IDX_W-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
    assign oob = 64'(addr) >= 64'(DEPTH);
`else
    logic unused_addr;
    assign oob         = 1'b0;
    assign unused_addr = ^addr;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        err_d   = err_q;
        oob_d   = oob_q;
        zero_d  = zero_q;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        rd_idx  = idx_q;
        case (state_q)
            IDLE: begin
                if (memory_read_en) begin
                    idx_d = addr_idx;
                    cnt_d = LAT_W'(READ_LAT - 1);
                    err_d = memory_write_en | oob;
                    oob_d = oob;
                    if (READ_LAT == 1) begin
                        rd_en   = 1'b1;
                        rd_idx  = addr_idx;
                        zero_d  = oob;
                        state_d = RESP;
                    end else begin
                        state_d = RD_WAIT;
                    end
                end else if (memory_write_en) begin
                    wr_en   = ~oob;
                    err_d   = oob;
                    state_d = RESP;
                end
            end
            RD_WAIT: begin
                if (cnt_q == '0) begin
                    rd_en   = 1'b1;
                    zero_d  = oob_q;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - LAT_W'(1);
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            err_q   <= 1'b0;
            oob_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            err_q   <= err_d;
            oob_q   <= oob_d;
            zero_q  <= zero_d;
        end
    end

    mem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem_array (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en_i  (wr_en),
        .wr_idx_i (addr_idx),
        .wr_dat_i (data_in),
        .rd_en_i  (rd_en),
        .rd_idx_i (rd_idx),
        .rd_dat_o (rd_dat)
    );

    // data_out is held from the last completed read; an out-of-range read forces zero.
    assign data_out = zero_q ? '0 : rd_dat;
    assign ready    = (state_q == RESP);
    assign busy     = (state_q != IDLE);
    assign err      = ready & err_q;

endmodule

// File: tb/tb_memory_ctrl.sv
// Directed table-driven bench for memory_ctrl (DATA_W=8, DEPTH=1024, READ_LAT=2).
module tb_memory_ctrl;

`ifdef MEM_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] addr = '0;
    logic [7:0]  data_in = '0;
    logic [7:0]  data_out;
    logic        rd_en = 1'b0;
    logic        wr_en = 1'b0;
    logic        ready, busy, err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    memory_ctrl #(
        .DATA_W   (8),
        .DEPTH    (1024),
        .READ_LAT (2),
        .ADDR_W   (32)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .addr            (addr),
        .data_in         (data_in),
        .data_out        (data_out),
        .memory_read_en  (rd_en),
        .memory_write_en (wr_en),
        .ready           (ready),
        .busy            (busy),
        .err             (err)
    );

    typedef struct {
        bit          rd;
        bit          wr;
        logic [31:0] a;
        logic [7:0]  d;
        int          lat;
        logic [7:0]  dout;
        bit          e;
    } vec_t;

    vec_t v[16];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one request, then look for its ready pulse on falling edges.
    task automatic run_req(input int n, input vec_t t);
        int lat;
        lat = 0;
        @(negedge clk);
        rd_en   = t.rd;
        wr_en   = t.wr;
        addr    = t.a;
        data_in = t.d;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        wr_en = 1'b0;
        for (int k = 1; k <= 20 && lat == 0; k++) begin
            @(negedge clk);
            if (ready) lat = k;
        end
        chk($sformatf("vec%0d latency", n), lat, t.lat);
        if (lat != 0) begin
            chk($sformatf("vec%0d data_out", n), {24'd0, data_out}, {24'd0, t.dout});
            chk($sformatf("vec%0d err", n), {31'd0, err}, {31'd0, t.e});
            @(negedge clk);
            chk($sformatf("vec%0d ready_drop", n), {31'd0, ready}, 32'd0);
        end
    endtask

    initial begin
        int pulses;
        int first;
        int last;
        bit gap_ok;
        bit data_ok;
        bit quiet;

        v[0]  = '{1'b1, 1'b0, 32'd5,    8'h00, 3, 8'h05, 1'b0};
        v[1]  = '{1'b0, 1'b1, 32'd17,   8'hA5, 1, 8'h05, 1'b0};
        v[2]  = '{1'b1, 1'b0, 32'd17,   8'h00, 3, 8'hA5, 1'b0};
        v[3]  = '{1'b1, 1'b1, 32'd3,    8'hFF, 3, 8'h03, 1'b1};
        v[4]  = '{1'b1, 1'b0, 32'd3,    8'h00, 3, 8'h03, 1'b0};
        v[5]  = '{1'b1, 1'b0, 32'd1029, 8'h00, 3, BC ? 8'h00 : 8'h05, BC};
        v[6]  = '{1'b0, 1'b1, 32'd1029, 8'h77, 1, BC ? 8'h00 : 8'h05, BC};
        v[7]  = '{1'b1, 1'b0, 32'd5,    8'h00, 3, BC ? 8'h05 : 8'h77, 1'b0};
        v[8]  = '{1'b1, 1'b0, 32'd1023, 8'h00, 3, 8'hFF, 1'b0};
        v[9]  = '{1'b0, 1'b1, 32'd1023, 8'h5A, 1, 8'hFF, 1'b0};
        v[10] = '{1'b1, 1'b0, 32'd1023, 8'h00, 3, 8'h5A, 1'b0};
        v[11] = '{1'b1, 1'b0, 32'd0,    8'h00, 3, 8'h00, 1'b0};
        v[12] = '{1'b1, 1'b0, 32'd300,  8'h00, 3, 8'h2C, 1'b0};
        v[13] = '{1'b1, 1'b0, 32'd1024, 8'h00, 3, 8'h00, BC};
        v[14] = '{1'b1, 1'b1, 32'd1029, 8'h11, 3, BC ? 8'h00 : 8'h77, 1'b1};
        v[15] = '{1'b1, 1'b0, 32'd5,    8'h00, 3, BC ? 8'h05 : 8'h77, 1'b0};

        repeat (3) @(negedge clk);
        chk("reset ready", {31'd0, ready}, 32'd0);
        chk("reset busy", {31'd0, busy}, 32'd0);
        chk("reset err", {31'd0, err}, 32'd0);
        chk("reset data_out", {24'd0, data_out}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            run_req(i, v[i]);
        end

        // Level-held read: one request per IDLE/RD_WAIT/RD_WAIT/RESP round.
        @(negedge clk);
        rd_en = 1'b1;
        addr  = 32'd9;
        pulses  = 0;
        first   = -1;
        last    = -1;
        gap_ok  = 1'b1;
        data_ok = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (ready) begin
                pulses++;
                if (first < 0) first = i;
                if (last >= 0 && i - last != 4) gap_ok = 1'b0;
                if (data_out !== 8'h09) data_ok = 1'b0;
                last = i;
            end
        end
        rd_en = 1'b0;
        chk("hold pulses", pulses, 3);
        chk("hold first pulse", first, 2);
        chk("hold spacing", {31'd0, gap_ok}, 32'd1);
        chk("hold data", {31'd0, data_ok}, 32'd1);
        repeat (2) @(negedge clk);

        // Reset while a read is waiting: it must never complete.
        rd_en = 1'b1;
        addr  = 32'd20;
        @(posedge clk);
        #1;
        rd_en = 1'b0;
        @(negedge clk);
        chk("rdwait busy", {31'd0, busy}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("midreset ready", {31'd0, ready}, 32'd0);
        chk("midreset busy", {31'd0, busy}, 32'd0);
        chk("midreset err", {31'd0, err}, 32'd0);
        chk("midreset data_out", {24'd0, data_out}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ready || busy) quiet = 1'b0;
        end
        chk("post reset quiet", {31'd0, quiet}, 32'd1);
        run_req(16, '{1'b1, 1'b0, 32'd7, 8'h00, 3, 8'h07, 1'b0});
        run_req(17, '{1'b1, 1'b0, 32'd17, 8'h00, 3, 8'hA5, 1'b0});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
